// File: rtl/prefix_sched.sv
// prefix_sched: shares one PREFIX engine between two requesters by buffering whole jobs,
// arbitrating round-robin and replaying each job as one burst. Watchdog: PREFIX_SCHED_TIMEOUT_EN.
//
//  state  | meaning
//  IDLE   | nothing in flight; grant a done buffer (pointer breaks ties)
//  SEND   | replay granted buffer to the engine, one token per cycle
//  WAIT   | burst complete, waiting for the engine result
//  RESP   | result held on rsp_* until the requester accepts it
module prefix_sched #(
  parameter int MAX_TOK = 19,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_opt,
  input  logic [4:0]  req0_data,
  input  logic        req0_last,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_opt,
  input  logic [4:0]  req1_data,
  input  logic        req1_last,
  output logic        eng_in_valid,
  output logic        eng_opt,
  output logic [4:0]  eng_in_data,
  input  logic        eng_out_valid,
  input  logic [94:0] eng_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [94:0] rsp_data,
  output logic        rsp_err
);

  localparam int CW = $clog2(MAX_TOK + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_RESP} state_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("prefix_sched: TIMEOUT must be at least 1");
  end

  logic [1:0]    vld, lst, opt_in, acc, clr;
  logic [4:0]    dat [2];

  logic [4:0]    mem_q [2][MAX_TOK];
  logic [CW-1:0] cnt_q [2];
  logic [1:0]    opt_q, done_q;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d, ptr_q, ptr_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          tmo_hit;

  logic          eng_in_valid_q, eng_in_valid_d;
  logic          eng_opt_q, eng_opt_d;
  logic [4:0]    eng_in_data_q, eng_in_data_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic          rsp_err_q, rsp_err_d;
  logic [94:0]   rsp_data_q, rsp_data_d;

  assign vld    = {req1_valid, req0_valid};
  assign lst    = {req1_last, req0_last};
  assign opt_in = {req1_opt, req0_opt};
  assign dat[0] = req0_data;
  assign dat[1] = req1_data;

  assign req0_ready = !done_q[0];
  assign req1_ready = !done_q[1];
  assign acc        = vld & ~done_q;
  assign clr[0]     = rsp_valid_q && rsp_ready && !rsp_id_q;
  assign clr[1]     = rsp_valid_q && rsp_ready && rsp_id_q;

  // A full buffer ends the job even without last.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst || clr[k]) begin
        cnt_q[k]  <= '0;
        done_q[k] <= 1'b0;
      end else if (acc[k]) begin
        mem_q[k][cnt_q[k]] <= dat[k];
        cnt_q[k]           <= cnt_q[k] + 1'b1;
        if (cnt_q[k] == '0) opt_q[k] <= opt_in[k];
        if (lst[k] || (cnt_q[k] == CW'(MAX_TOK - 1))) done_q[k] <= 1'b1;
      end
      if (rst) opt_q[k] <= 1'b0;
    end
  end

`ifdef PREFIX_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;

  always_ff @(posedge clk) begin
    if (rst || (state_q != S_WAIT)) tmo_q <= '0;
    else                            tmo_q <= tmo_q + 1'b1;
  end

  assign tmo_hit = (state_q == S_WAIT) && (tmo_q == TW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      gnt_q          <= 1'b0;
      ptr_q          <= 1'b0;
      idx_q          <= '0;
      eng_in_valid_q <= 1'b0;
      eng_opt_q      <= 1'b0;
      eng_in_data_q  <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      ptr_q          <= ptr_d;
      idx_q          <= idx_d;
      eng_in_valid_q <= eng_in_valid_d;
      eng_opt_q      <= eng_opt_d;
      eng_in_data_q  <= eng_in_data_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_err_q      <= rsp_err_d;
      rsp_data_q     <= rsp_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (done_q != 2'b00) begin
          gnt_d   = (done_q == 2'b11) ? ptr_q : done_q[1];
          ptr_d   = ~gnt_d;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (idx_q == cnt_q[gnt_q] - 1'b1) state_d = S_WAIT;
        else                              idx_d   = idx_q + 1'b1;
      end
      S_WAIT: begin
        if (eng_out_valid || tmo_hit) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    eng_in_valid_d = (state_d == S_SEND);
    eng_opt_d      = 1'b0;
    eng_in_data_d  = '0;
    if (state_d == S_SEND) begin
      eng_opt_d     = opt_q[gnt_d];
      eng_in_data_d = mem_q[gnt_d][idx_d];
    end
    rsp_valid_d = (state_d == S_RESP);
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    if ((state_q == S_WAIT) && (state_d == S_RESP)) begin
      rsp_id_d   = gnt_q;
      rsp_data_d = eng_out_valid ? eng_out : '0;
      rsp_err_d  = tmo_hit && !eng_out_valid;
    end
  end

  assign eng_in_valid = eng_in_valid_q;
  assign eng_opt      = eng_opt_q;
  assign eng_in_data  = eng_in_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_prefix_sched.sv
// tb_prefix_sched: directed scoreboard bench for prefix_sched; the bench plays both requesters
// and the engine, predicting token bursts and responses in service order.
module tb_prefix_sched;
  localparam int MAX_TOK = 19;
`ifdef PREFIX_SCHED_TIMEOUT_EN
  localparam int TIMEOUT = 16;
`else
  localparam int TIMEOUT = 1024;
`endif
  localparam int BOUND = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req0_opt = 1'b0, req0_last = 1'b0, req0_ready;
  logic        req1_valid = 1'b0, req1_opt = 1'b0, req1_last = 1'b0, req1_ready;
  logic [4:0]  req0_data = '0, req1_data = '0;
  logic        eng_in_valid, eng_opt;
  logic [4:0]  eng_in_data;
  logic        eng_out_valid = 1'b0;
  logic [94:0] eng_out = '0;
  logic        rsp_valid, rsp_id, rsp_err;
  logic        rsp_ready = 1'b1;
  logic [94:0] rsp_data;

  prefix_sched #(.MAX_TOK(MAX_TOK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opt(req0_opt),
    .req0_data(req0_data), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opt(req1_opt),
    .req1_data(req1_data), .req1_last(req1_last),
    .eng_in_valid(eng_in_valid), .eng_opt(eng_opt), .eng_in_data(eng_in_data),
    .eng_out_valid(eng_out_valid), .eng_out(eng_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [94:0] data;
  } rsp_t;

  logic [5:0] exp_tok[$];
  rsp_t       exp_rsp[$];
  int         starts[$], lens[$], hss[$];
  int         total = 0, bad = 0, cyc = 0, nb = 0, nr = 0;
  int         run_start = 0, run_len = 0;
  logic       prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops expected tokens/responses as the DUT produces them.
  always @(negedge clk) begin
    logic [5:0] e;
    rsp_t       r;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (eng_in_valid) begin
        if (!prev_v) begin
          run_start = cyc;
          run_len   = 0;
        end
        run_len++;
        if (exp_tok.size() == 0) chk("eng_tok_extra", exp_tok.size(), 1);
        else begin
          e = exp_tok.pop_front();
          chk("eng_tok", {eng_opt, eng_in_data}, e);
        end
      end else begin
        if (prev_v) begin
          starts.push_back(run_start);
          lens.push_back(run_len);
        end
        chk("eng_idle_zero", {eng_opt, eng_in_data}, 6'h00);
      end
      prev_v = eng_in_valid;
      if (rsp_valid && rsp_ready) begin
        hss.push_back(cyc);
        if (exp_rsp.size() == 0) chk("rsp_extra", exp_rsp.size(), 1);
        else begin
          r = exp_rsp.pop_front();
          chk("rsp", {rsp_id, rsp_err, rsp_data}, r);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_job(input int k, input int n, input logic opt, input int base,
                            input logic [94:0] val, input logic err);
    rsp_t r;
    for (int i = 0; i < n; i++) exp_tok.push_back({opt, 5'(base + i)});
    r.id   = 1'(k);
    r.err  = err;
    r.data = val;
    exp_rsp.push_back(r);
  endtask

  task automatic send_job(input int k, input int n, input logic opt, input logic use_last,
                          input int base);
    for (int i = 0; i < n; i++) begin
      if (k == 0) begin
        chk("req0_ready_open", req0_ready, 1'b1);
        req0_valid = 1'b1;
        req0_data  = 5'(base + i);
        req0_opt   = (i == 0) ? opt : ~opt;
        req0_last  = use_last && (i == n - 1);
      end else begin
        chk("req1_ready_open", req1_ready, 1'b1);
        req1_valid = 1'b1;
        req1_data  = 5'(base + i);
        req1_opt   = (i == 0) ? opt : ~opt;
        req1_last  = use_last && (i == n - 1);
      end
      step();
    end
    if (k == 0) begin
      req0_valid = 1'b0;
      req0_last  = 1'b0;
      chk("req0_ready_done", req0_ready, 1'b0);
    end else begin
      req1_valid = 1'b0;
      req1_last  = 1'b0;
      chk("req1_ready_done", req1_ready, 1'b0);
    end
  endtask

  task automatic wait_burst(input int len);
    int t = 0;
    nb++;
    while (lens.size() < nb && t < BOUND) begin
      step();
      t++;
    end
    chk("burst_done", lens.size() >= nb, 1'b1);
    if (lens.size() >= nb) chk("burst_len", lens[nb-1], len);
  endtask

  task automatic engine_reply(input logic [94:0] val, input int delay, input int len);
    wait_burst(len);
    repeat (delay) step();
    eng_out_valid = 1'b1;
    eng_out       = val;
    step();
    eng_out_valid = 1'b0;
    eng_out       = '0;
    chk("rsp_rise", rsp_valid, 1'b1);
  endtask

  task automatic wait_rsp();
    int t = 0;
    nr++;
    while (hss.size() < nr && t < BOUND) begin
      step();
      t++;
    end
    chk("rsp_handshake", hss.size() >= nr, 1'b1);
  endtask

  task automatic chk_reset();
    chk("rst_req0_ready", req0_ready, 1'b1);
    chk("rst_req1_ready", req1_ready, 1'b1);
    chk("rst_eng_in_valid", eng_in_valid, 1'b0);
    chk("rst_eng_opt", eng_opt, 1'b0);
    chk("rst_eng_in_data", eng_in_data, 5'd0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_data", rsp_data, 95'd0);
    chk("rst_rsp_err", rsp_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, r, d, t, w0;
    repeat (3) step();
    rst = 1'b0;
    chk_reset();

    // Contention right after reset: req0 first.
    b = nb; r = nr;
    expect_job(0, 4, 1'b0, 10, 95'h11, 1'b0);
    expect_job(1, 4, 1'b1, 20, 95'h22, 1'b0);
    fork
      send_job(0, 4, 1'b0, 1'b1, 10);
      send_job(1, 4, 1'b1, 1'b1, 20);
    join
    engine_reply(95'h11, 1, 4);
    engine_reply(95'h22, 2, 4);
    wait_rsp();
    wait_rsp();
    chk("b2b_gap", starts[b+1], hss[r] + 2);

    // Single full-length job with last on token 19.
    expect_job(0, 19, 1'b1, 3, 95'h5, 1'b0);
    send_job(0, 19, 1'b1, 1'b1, 3);
    d = cyc;
    engine_reply(95'h5, 3, 19);
    chk("first_tok_latency", starts[nb-1], d + 1);
    wait_rsp();
    chk("req0_ready_reopen", req0_ready, 1'b1);
    chk("rsp_drop", rsp_valid, 1'b0);

    // Second simultaneous pair: pointer now favours req1.
    expect_job(1, 3, 1'b0, 25, 95'h33, 1'b0);
    expect_job(0, 6, 1'b1, 5, 95'h44, 1'b0);
    fork
      send_job(0, 6, 1'b1, 1'b1, 5);
      send_job(1, 3, 1'b0, 1'b1, 25);
    join
    engine_reply(95'h33, 0, 3);
    engine_reply(95'h44, 4, 6);
    wait_rsp();
    wait_rsp();

    // Overlap: req1 streams while req0 is in SEND/WAIT.
    b = nb; r = nr;
    expect_job(0, 5, 1'b1, 0, 95'h55, 1'b0);
    expect_job(1, 7, 1'b0, 12, {31'h7fff_ffff, 64'hdead_beef_0123_4567}, 1'b0);
    send_job(0, 5, 1'b1, 1'b1, 0);
    fork
      send_job(1, 7, 1'b0, 1'b1, 12);
      engine_reply(95'h55, 8, 5);
    join
    engine_reply({31'h7fff_ffff, 64'hdead_beef_0123_4567}, 0, 7);
    wait_rsp();
    wait_rsp();
    chk("overlap_start", starts[b+1], hss[r] + 2);

    // Forced end at MAX_TOK plus response backpressure.
    expect_job(0, MAX_TOK, 1'b0, 7, 95'h77, 1'b0);
    send_job(0, MAX_TOK, 1'b0, 1'b0, 7);
    rsp_ready = 1'b0;
    engine_reply(95'h77, 2, MAX_TOK);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_id", rsp_id, 1'b0);
      chk("bp_data", rsp_data, 95'h77);
      chk("bp_err", rsp_err, 1'b0);
      chk("bp_req0_ready", req0_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    wait_rsp();
    chk("req0_ready_after_bp", req0_ready, 1'b1);

    // Engine pulse while idle is discarded.
    eng_out_valid = 1'b1;
    eng_out       = 95'h99;
    step();
    eng_out_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("idle_pulse_ignored", rsp_valid, 1'b0);
      step();
    end

    // Reset on cycle 5 of a burst.
    expect_job(1, 10, 1'b1, 50, 95'h88, 1'b0);
    send_job(1, 10, 1'b1, 1'b1, 50);
    repeat (5) step();
    chk("pre_rst_valid", eng_in_valid, 1'b1);
    rst = 1'b1;
    step();
    chk_reset();
    rst = 1'b0;
    exp_tok.delete();
    exp_rsp.delete();
    for (int i = 0; i < 20; i++) begin
      chk("post_rst_no_rsp", rsp_valid, 1'b0);
      chk("post_rst_no_send", eng_in_valid, 1'b0);
      step();
    end

`ifdef PREFIX_SCHED_TIMEOUT_EN
    expect_job(0, 3, 1'b0, 1, 95'h0, 1'b1);
    send_job(0, 3, 1'b0, 1'b1, 1);
    rsp_ready = 1'b0;
    wait_burst(3);
    w0 = starts[nb-1] + lens[nb-1];
    t = 0;
    while (!rsp_valid && t < BOUND) begin
      step();
      t++;
    end
    chk("tmo_latency", cyc, w0 + 16);
    chk("tmo_err", rsp_err, 1'b1);
    chk("tmo_data", rsp_data, 95'd0);
    eng_out_valid = 1'b1;
    eng_out       = 95'h1234;
    step();
    eng_out_valid = 1'b0;
    chk("tmo_late_data", rsp_data, 95'd0);
    chk("tmo_late_err", rsp_err, 1'b1);
    rsp_ready = 1'b1;
    wait_rsp();
    eng_out_valid = 1'b1;
    step();
    eng_out_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("tmo_late_ignored", rsp_valid, 1'b0);
      step();
    end
`else
    w0 = 0;
    t  = 0;
`endif

    chk("sb_tok_empty", exp_tok.size(), 0);
    chk("sb_rsp_empty", exp_rsp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
